// File: rtl/ef_apb_pkg.sv
// Shared types and sizing helpers for the APB requester.
package ef_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Watchdog counter width; at least one bit even when the watchdog is disabled.
  function automatic int unsigned wdog_cnt_w(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/ef_apb_wdog.sv
// Per-transfer ACCESS-phase watchdog: counts stalled cycles, flags the last one.
module ef_apb_wdog
  import ef_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic cnt_en,
  output logic expired_c
);

  localparam int unsigned   CW   = wdog_cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate at LAST so a disabled or expired watchdog never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c = (TIMEOUT != 0) && cnt_en && (cnt_q == LAST);

endmodule

// File: rtl/ef_apb_requester.sv
// APB3 initiator: one valid/ready command becomes one APB transfer and one response.
module ef_apb_requester
  import ef_apb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic          busy,
  output logic [AW-1:0] PADDR,
  output logic          PWRITE,
  output logic [DW-1:0] PWDATA,
  output logic          PSEL,
  output logic          PENABLE,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  state_e        state_q, state_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic          pwrite_q, pwrite_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;
  logic          expired_c;

  ef_apb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .clear     (state_q == ST_SETUP),
    .cnt_en    ((state_q == ST_ACCESS) && !PREADY),
    .expired_c (expired_c)
  );

  // Next-state and datapath; a slave completion beats a same-cycle watchdog abort.
  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          rdata_d = pwrite_q ? '0 : PRDATA;
          err_d   = PSLVERR;
          tmo_d   = 1'b0;
          state_d = ST_RESP;
        end else if (expired_c) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d = (state_d == ST_ACCESS);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  // Handshake/status outputs decode state; cmd_ready is also held low during reset.
  assign cmd_ready   = (state_q == ST_IDLE) && PRESETn;
  assign rsp_valid   = (state_q == ST_RESP);
  assign busy        = (state_q != ST_IDLE);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;

endmodule

// File: tb/tb_ef_apb_requester.sv
// Scoreboard bench for ef_apb_requester with a configurable APB slave model.
module tb_ef_apb_requester;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          busy;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  ef_apb_requester #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Slave model: PREADY after sl_waits wait states unless stuck.
  int          sl_waits = 0;
  logic        sl_stuck = 1'b0;
  logic [31:0] sl_rdata = '0;
  logic        sl_err = 1'b0;
  int          wcnt = 0;

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
  end
  assign PREADY  = PSEL && PENABLE && !sl_stuck && (wcnt == sl_waits);
  assign PRDATA  = sl_rdata;
  assign PSLVERR = sl_err && PREADY;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: bus signals track the outstanding command; responses compared against scoreboard.
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      seen = 1'b0;
    end else begin
      if (PSEL || rsp_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_bus_activity psel=%b rsp_valid=%b required idle", PSEL, rsp_valid);
        end else begin
          chk("paddr", PADDR, sb[0].addr);
          chk("pwrite", 32'(PWRITE), 32'(sb[0].wr));
          if (sb[0].wr) chk("pwdata", PWDATA, sb[0].wdata);
        end
      end
      if (rsp_valid && sb.size() != 0) begin
        if (!seen) begin
          seen = 1'b1;
          chk("rsp_latency", 32'((cyc + 1) - sb[0].acc), 32'(sb[0].lat));
        end
        chk("rsp_rdata", rsp_rdata, sb[0].rdata);
        chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(sb[0].tmo));
        if (rsp_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Offer one command (called just after a rising edge); returns just after the accept edge.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int waits, input logic stuck, input logic [31:0] srdata,
                       input logic serr, input logic [31:0] e_rdata, input logic e_err,
                       input logic e_tmo, input int lat);
    exp_t e;
    int   n;
    sl_waits  = waits;
    sl_stuck  = stuck;
    sl_rdata  = srdata;
    sl_err    = serr;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge PCLK);
      if (cmd_ready) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL cmd_accept_timeout cmd_ready=%b required 1", cmd_ready);
        break;
      end
    end
    e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = e_rdata;
    e.err = e_err; e.tmo = e_tmo; e.lat = lat; e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL rsp_drain_timeout pending=%0d required 0", sb.size());
      sb.delete();
    end
    @(posedge PCLK); #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Zero-wait write with phase timing
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'hFFFF_FFFF, 1'b0,
          32'h0, 1'b0, 1'b0, 3);
    @(negedge PCLK);
    chk("setup_psel", 32'(PSEL), 32'd1);
    chk("setup_penable", 32'(PENABLE), 32'd0);
    @(negedge PCLK);
    chk("access_psel", 32'(PSEL), 32'd1);
    chk("access_penable", 32'(PENABLE), 32'd1);
    drain();

    // Read with three wait states
    issue(1'b0, 32'h0000_0004, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b0,
          32'h1234_5678, 1'b0, 1'b0, 6);
    drain();

    // Read completing with slave error
    issue(1'b0, 32'h0000_0008, 32'h0, 0, 1'b0, 32'hBAD0_0001, 1'b1,
          32'hBAD0_0001, 1'b1, 1'b0, 3);
    drain();

    // Watchdog abort, then PREADY on the final allowed cycle
    issue(1'b0, 32'h0000_0030, 32'h0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0,
          32'h0, 1'b1, 1'b1, 2 + TMO);
    drain();
    issue(1'b0, 32'h0000_0034, 32'h0, TMO - 1, 1'b0, 32'h0BAD_CAFE, 1'b0,
          32'h0BAD_CAFE, 1'b0, 1'b0, 2 + TMO);
    drain();

    // Response back-pressure while a new command is offered
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_0020, 32'h0, 1, 1'b0, 32'hCAFE_F00D, 1'b0,
          32'hCAFE_F00D, 1'b0, 1'b0, 4);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0099;
    cmd_wdata = 32'h5555_AAAA;
    for (int i = 0; i < 13; i++) begin
      @(negedge PCLK);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      if (i >= 3) chk("hold_psel", 32'(PSEL), 32'd0);
    end
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    @(negedge PCLK);
    chk("post_hold_psel", 32'(PSEL), 32'd0);
    @(posedge PCLK); #1;

    // Reset during ACCESS, then a normal write with throughput check
    issue(1'b0, 32'h0000_0040, 32'h0, 0, 1'b1, 32'h0, 1'b0,
          32'h0, 1'b1, 1'b1, 2 + TMO);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("pre_rst_penable", 32'(PENABLE), 32'd1);
    PRESETn = 1'b0;
    @(negedge PCLK);
    chk("midrst_psel", 32'(PSEL), 32'd0);
    chk("midrst_penable", 32'(PENABLE), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    sb.delete();
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    sl_stuck = 1'b0;
    @(posedge PCLK); #1;
    issue(1'b1, 32'h0000_0044, 32'h0102_0304, 0, 1'b0, 32'hFFFF_FFFF, 1'b0,
          32'h0, 1'b0, 1'b0, 3);
    for (int i = 1; i <= 4; i++) begin
      @(negedge PCLK);
      chk("cmd_ready_return", 32'(cmd_ready), (i == 4) ? 32'd1 : 32'd0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required completion", $time);
    $fatal(1, "bench timeout");
  end

endmodule
